cr_cmd_rx: RTL and testbench
============================

Name: cr_cmd_rx

Overview:
Host-side command receiver that sits directly upstream of the correlator command decoder. It accepts a byte stream from the host link and frames it into commands. For each complete command it drives a single-cycle write strobe with a 4-bit opcode and, for configuration opcodes, an assembled data word. It enforces the minimum strobe spacing the decoder needs, and it rejects malformed or stalled frames.

Parameters:
DATA_W, 32, payload word width; must be a multiple of 8; PAYLOAD_BYTES = DATA_W/8
SYNC, 4'hC, required upper nibble of a header byte
TIMEOUT, 1024, maximum idle cycles allowed between payload bytes
GAP, 2, hold-off cycles after each cmd_we (minimum 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  host byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  receiver can accept a byte; a byte transfers when rx_valid & rx_ready
cmd_we  out  1  one-cycle command strobe to the decoder
cmd_opcode  out  4  command opcode; held between strobes
cmd_data  out  DATA_W  command payload; held between strobes
frame_err  out  1  one-cycle pulse on a rejected header or a payload timeout
busy  out  1  high whenever state != HUNT

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=HUNT; shift register, byte count and timer cleared.
  - cmd_we=0, frame_err=0, cmd_opcode=0, cmd_data=0.
  - Any partial frame is discarded. Reset has priority over all other events.
- Opcode classes:
  - Control opcodes (0x0 STOP, 0x1 START, 0x2 SW_RST) carry no payload.
  - Data opcodes (0x4 LPF1, 0x5 LPF2, 0x6 HTF, 0x8 CLK_GEN) carry PAYLOAD_BYTES bytes, MSB first.
  - All other opcodes are invalid.
- rx_ready is 1 in HUNT and PAYLOAD, and 0 in ISSUE and HOLD.
- States:
  - HUNT: on an accepted byte:
    - rx_data[7:4]==SYNC and control opcode: latch the opcode, go to ISSUE, and set the payload to zero.
    - rx_data[7:4]==SYNC and data opcode: latch the opcode into a pending register, clear the shift register, byte count and timer, and go to PAYLOAD.
    - Bad sync nibble or invalid opcode: frame_err=1 on the next cycle, stay in HUNT.
  - PAYLOAD: on an accepted byte:
    - shift = {shift[DATA_W-9:0], rx_data}; count++; timer cleared.
    - When the byte accepted is number PAYLOAD_BYTES, go to ISSUE.
  - PAYLOAD with no byte accepted in a cycle:
    - timer++.
    - If timer==TIMEOUT-1: go to HUNT, assert frame_err=1 on the next cycle, and discard the partial payload. cmd_data and cmd_opcode are left unchanged.
  - ISSUE: cmd_we=1 for exactly one cycle. cmd_opcode and cmd_data are loaded on entry to ISSUE, so they are stable while cmd_we=1. Go to HOLD with the hold counter at 0.
  - HOLD: stay for GAP cycles, then go to HUNT.
- Latency:
  - The final byte of a frame accepted at edge t produces cmd_we=1 in cycle t+1.
  - The next byte can be accepted no earlier than t+2+GAP.
  - With GAP=2, consecutive strobes are at least 4 cycles apart, which covers the decoder's IDLE→DECODE→IDLE sequence.
- cmd_data and cmd_opcode change only on entry to ISSUE. They do not change while a payload is being assembled.
- frame_err and cmd_we are never both 1 in the same cycle.
- A header byte that arrives while in PAYLOAD is treated as payload data. Frames do not resynchronise mid-payload; only a timeout or rst returns the block to HUNT.

Test Plan:
- Send 0xC1 with rx_valid=1 for one cycle → cmd_we=1 for one cycle the cycle after acceptance; cmd_opcode=1, cmd_data=0; rx_ready=0 for 3 cycles; busy=1 for 3 cycles.
- Send 0xC4,0x12,0x34,0x56,0x78 with gaps of 0–5 idle cycles between bytes → exactly one cmd_we; cmd_opcode=4, cmd_data=0x12345678; cmd_data keeps its previous value until the strobe.
- Send 0xC3, then 0x51 → frame_err pulses once for each byte; no cmd_we; rx_ready stays 1; state remains HUNT.
- Send 0xC6,0xAA,0xBB, then hold rx_valid=0 for TIMEOUT cycles → one frame_err pulse, busy drops to 0, no cmd_we. Then send 0xC0 → cmd_we with opcode 0 and cmd_data=0.
- Hold rx_valid=1 continuously while presenting 0xC1 then 0xC0 → the second byte is accepted 4 cycles after the first; the two cmd_we pulses are exactly 4 cycles apart.
- Send 0xC8,0x01,0x02, assert rst for 1 cycle, then send 0xC2 → after rst all outputs are 0; cmd_we with opcode 2 and cmd_data=0; no frame_err.

Source files
------------

// File: rtl/cr_cmd_rx.sv
// Host byte-stream command receiver: frames header/payload bytes into single-cycle
// command strobes for the correlator decoder, with strobe spacing and frame checks.
module cr_cmd_rx #(
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  SYNC    = 4'hC,
  parameter int          TIMEOUT = 1024,
  parameter int          GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              cmd_we,
  output logic [3:0]        cmd_opcode,
  output logic [DATA_W-1:0] cmd_data,
  output logic              frame_err,
  output logic              busy
);

  // state   | meaning
  // HUNT    | waiting for a header byte
  // PAYLOAD | collecting payload bytes MSB first, idle timer running
  // ISSUE   | cmd_we asserted for one cycle
  // HOLD    | decoder hold-off, GAP cycles
  typedef enum logic [1:0] {HUNT, PAYLOAD, ISSUE, HOLD} state_t;

  localparam int PAYLOAD_BYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(GAP + 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [3:0]          pending_q, pending_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                accept;
  logic                sync_ok, ctrl_op, data_op;
  logic [DATA_W-1:0]   shift_in;

  assign rx_ready   = (state_q == HUNT) || (state_q == PAYLOAD);
  assign accept     = rx_valid && rx_ready;
  assign cmd_we     = (state_q == ISSUE);
  assign busy       = (state_q != HUNT);
  assign cmd_opcode = opcode_q;
  assign cmd_data   = data_q;
  assign frame_err  = err_q;

  assign sync_ok  = (rx_data[7:4] == SYNC);
  assign ctrl_op  = rx_data[3:0] inside {4'h0, 4'h1, 4'h2};
  assign data_op  = rx_data[3:0] inside {4'h4, 4'h5, 4'h6, 4'h8};
  // Shift rather than slice so an 8-bit payload width also elaborates
  assign shift_in = (shift_q << 8) | DATA_W'(rx_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      shift_q   <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
      pending_q <= '0;
      opcode_q  <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      opcode_q  <= opcode_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    opcode_d  = opcode_q;
    data_d    = data_q;
    err_d     = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept) begin
          if (sync_ok && ctrl_op) begin
            opcode_d = rx_data[3:0];
            data_d   = '0;
            state_d  = ISSUE;
          end else if (sync_ok && data_op) begin
            pending_d = rx_data[3:0];
            shift_d   = '0;
            count_d   = '0;
            timer_d   = '0;
            state_d   = PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          shift_d = shift_in;
          count_d = count_q + 1'b1;
          timer_d = '0;
          if (count_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
            opcode_d = pending_q;
            data_d   = shift_in;
            state_d  = ISSUE;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // Partial payload is dropped; the last issued command stays visible
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ISSUE: begin
        hold_d  = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == HOLD_W'(GAP - 1)) state_d = HUNT;
        else                            hold_d  = hold_q + 1'b1;
      end
      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_cr_cmd_rx.sv
// Directed self-checking bench for cr_cmd_rx: control and data frames, bad headers,
// payload timeout, back-to-back strobe spacing and mid-frame reset.
module tb_cr_cmd_rx;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              cmd_we;
  logic [3:0]        cmd_opcode;
  logic [DATA_W-1:0] cmd_data;
  logic              frame_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  logic both_seen = 1'b0;

  cr_cmd_rx #(.DATA_W(DATA_W), .SYNC(4'hC), .TIMEOUT(TIMEOUT), .GAP(2)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cmd_we(cmd_we), .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (cmd_we) we_cnt <= we_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (cmd_we && frame_err) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a byte, wait (bounded) for rx_ready, and return just after it transfers
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (!rx_ready) check("send_ready_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl [4];
    int gaps [4];
    int w0, e0, n;
    logic found;
    pl   = '{8'h12, 8'h34, 8'h56, 8'h78};
    gaps = '{0, 3, 5, 1};

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_cmd_we", 32'(cmd_we), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_opcode", 32'(cmd_opcode), 32'd0);
    check("rst_data", cmd_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);

    // Control command START
    send_byte(8'hC1);
    check("c1_we", 32'(cmd_we), 32'd1);
    check("c1_opcode", 32'(cmd_opcode), 32'd1);
    check("c1_data", cmd_data, 32'd0);
    check("c1_ready0", 32'(rx_ready), 32'd0);
    check("c1_busy0", 32'(busy), 32'd1);
    tick();
    check("c1_we_single", 32'(cmd_we), 32'd0);
    check("c1_ready1", 32'(rx_ready), 32'd0);
    tick();
    check("c1_ready2", 32'(rx_ready), 32'd0);
    check("c1_busy2", 32'(busy), 32'd1);
    tick();
    check("c1_ready_back", 32'(rx_ready), 32'd1);
    check("c1_busy_back", 32'(busy), 32'd0);

    // Data command LPF1 with idle gaps between payload bytes
    w0 = we_cnt;
    send_byte(8'hC4);
    check("lpf1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) tick();
      check("lpf1_data_held", cmd_data, 32'd0);
      check("lpf1_opcode_held", 32'(cmd_opcode), 32'd1);
      check("lpf1_no_early_we", 32'(cmd_we), 32'd0);
      send_byte(pl[i]);
    end
    check("lpf1_we", 32'(cmd_we), 32'd1);
    check("lpf1_opcode", 32'(cmd_opcode), 32'd4);
    check("lpf1_data", cmd_data, 32'h12345678);
    repeat (3) tick();
    check("lpf1_we_count", 32'(we_cnt - w0), 32'd1);

    // Invalid opcode, then bad sync nibble
    w0 = we_cnt; e0 = err_cnt;
    send_byte(8'hC3);
    check("badop_err", 32'(frame_err), 32'd1);
    check("badop_ready", 32'(rx_ready), 32'd1);
    check("badop_busy", 32'(busy), 32'd0);
    tick();
    check("badop_err_pulse", 32'(frame_err), 32'd0);
    send_byte(8'h51);
    check("badsync_err", 32'(frame_err), 32'd1);
    check("badsync_ready", 32'(rx_ready), 32'd1);
    tick();
    check("bad_err_count", 32'(err_cnt - e0), 32'd2);
    check("bad_no_we", 32'(we_cnt - w0), 32'd0);

    // Stalled HTF payload times out
    w0 = we_cnt; e0 = err_cnt;
    send_byte(8'hC6); send_byte(8'hAA); send_byte(8'hBB);
    repeat (TIMEOUT - 2) tick();
    check("to_still_busy", 32'(busy), 32'd1);
    check("to_no_early_err", 32'(err_cnt - e0), 32'd0);
    found = 1'b0; n = 0;
    while (!found && n < 8) begin
      tick();
      found = frame_err;
      n++;
    end
    check("to_err_seen", 32'(found), 32'd1);
    check("to_busy_low", 32'(busy), 32'd0);
    check("to_opcode_kept", 32'(cmd_opcode), 32'd4);
    check("to_data_kept", cmd_data, 32'h12345678);
    tick();
    check("to_err_count", 32'(err_cnt - e0), 32'd1);
    check("to_no_we", 32'(we_cnt - w0), 32'd0);
    send_byte(8'hC0);
    check("stop_we", 32'(cmd_we), 32'd1);
    check("stop_opcode", 32'(cmd_opcode), 32'd0);
    check("stop_data", cmd_data, 32'd0);
    repeat (3) tick();

    // Back-to-back headers with rx_valid held high
    rx_data = 8'hC1; rx_valid = 1'b1;
    tick();
    check("b2b_we1", 32'(cmd_we), 32'd1);
    check("b2b_op1", 32'(cmd_opcode), 32'd1);
    rx_data = 8'hC0;
    tick();
    check("b2b_gap1_we", 32'(cmd_we), 32'd0);
    check("b2b_gap1_ready", 32'(rx_ready), 32'd0);
    tick();
    check("b2b_gap2_ready", 32'(rx_ready), 32'd0);
    tick();
    check("b2b_gap3_ready", 32'(rx_ready), 32'd1);
    check("b2b_gap3_we", 32'(cmd_we), 32'd0);
    tick();
    rx_valid = 1'b0;
    check("b2b_we2", 32'(cmd_we), 32'd1);
    check("b2b_op2", 32'(cmd_opcode), 32'd0);
    repeat (3) tick();

    // Reset in the middle of a CLK_GEN payload
    send_byte(8'hC8); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_we", 32'(cmd_we), 32'd0);
    check("mrst_err", 32'(frame_err), 32'd0);
    check("mrst_opcode", 32'(cmd_opcode), 32'd0);
    check("mrst_data", cmd_data, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(rx_ready), 32'd1);
    e0 = err_cnt;
    send_byte(8'hC2);
    check("swrst_we", 32'(cmd_we), 32'd1);
    check("swrst_opcode", 32'(cmd_opcode), 32'd2);
    check("swrst_data", cmd_data, 32'd0);
    repeat (3) tick();
    check("swrst_no_err", 32'(err_cnt - e0), 32'd0);

    check("we_err_exclusive", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
